// File: rtl/sdu_uart_tx.sv
// sdu_uart_tx
//
// Host-side UART transmitter for the SDU debug link. A small byte FIFO buffers
// command bytes from a producer. The FIFO is drained into 8N1 frames, sent LSB
// first, on a serial line that feeds the SDU's rxd input. The block runs in the
// SDU baud clock domain, with CLK_DIV clock cycles per serial bit.
//
// Parameters:
//   CLK_DIV     clock cycles per serial bit (2..65535)
//   FIFO_DEPTH  byte FIFO depth, power of two (2..256)
//
// Ports:
//   clk       block clock (SDU baud clock)
//   rst       asynchronous, active-high reset
//   din       byte to transmit
//   din_vld   producer strobe; a byte is accepted on an edge with din_vld && din_rdy
//   din_rdy   FIFO not full (combinational from fifo_cnt)
//   txd       registered serial output, idle-high
//   busy      a frame is on the line or the FIFO holds data
//   fifo_cnt  current FIFO occupancy
module sdu_uart_tx #(
  parameter int unsigned CLK_DIV    = 16,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    din,
  input  logic                          din_vld,
  output logic                          din_rdy,
  output logic                          txd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned BW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [BW-1:0] BCNT_LAST = BW'(CLK_DIV - 1);
  localparam logic [AW:0]   CNT_FULL  = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t state;

  // The pointers are one bit wider than the address, so that a full FIFO and
  // an empty FIFO give different pointer differences.
  logic [AW:0]   wptr;
  logic [AW:0]   rptr;
  logic [7:0]    mem [FIFO_DEPTH];

  logic [BW-1:0] bcnt;
  logic [2:0]    bit_idx;
  logic [7:0]    sh;

  logic          push;
  logic          pop;
  logic          bit_end;
  logic          fifo_nonempty;

  assign fifo_cnt      = wptr - rptr;
  assign fifo_nonempty = (fifo_cnt != '0);
  assign din_rdy       = (fifo_cnt != CNT_FULL);
  assign push          = din_vld && din_rdy;
  assign bit_end       = (bcnt == BCNT_LAST);
  assign busy          = (state != IDLE) || fifo_nonempty;

  // The FSM takes the head byte when it leaves IDLE, or at the end of a stop
  // bit, so that back-to-back frames follow each other with no idle gap.
  always_comb begin
    pop = 1'b0;
    if (fifo_nonempty) begin
      if (state == IDLE) begin
        pop = 1'b1;
      end else if ((state == STOP) && bit_end) begin
        pop = 1'b1;
      end
    end
  end

  // FIFO pointers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
    end
  end

  // FIFO storage; it is not reset, because occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr[AW-1:0]] <= din;
    end
  end

  // Framing FSM. txd is registered from the current state and sh, so the line
  // lags the state by one cycle and every bit still lasts CLK_DIV cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      bcnt    <= '0;
      bit_idx <= '0;
      sh      <= '0;
      txd     <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          txd <= 1'b1;
          if (pop) begin
            sh    <= mem[rptr[AW-1:0]];
            bcnt  <= '0;
            state <= START;
          end
        end

        START: begin
          txd <= 1'b0;
          if (bit_end) begin
            bcnt    <= '0;
            bit_idx <= '0;
            state   <= DATA;
          end else begin
            bcnt <= bcnt + 1'b1;
          end
        end

        DATA: begin
          txd <= sh[0];
          if (bit_end) begin
            bcnt <= '0;
            sh   <= {1'b0, sh[7:1]};
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            bcnt <= bcnt + 1'b1;
          end
        end

        STOP: begin
          txd <= 1'b1;
          if (bit_end) begin
            bcnt <= '0;
            if (pop) begin
              sh    <= mem[rptr[AW-1:0]];
              state <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            bcnt <= bcnt + 1'b1;
          end
        end

        default: begin
          txd   <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdu_uart_tx.sv
// Testbench for sdu_uart_tx with CLK_DIV=4 and FIFO_DEPTH=4.
module tb_sdu_uart_tx;

  logic       clk;
  logic       rst;
  logic [7:0] din;
  logic       din_vld;
  logic       din_rdy;
  logic       txd;
  logic       busy;
  logic [2:0] fifo_cnt;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  bit dec_en = 0;

  logic [7:0] rx_q[$];
  int         st_q[$];

  sdu_uart_tx #(
    .CLK_DIV    (4),
    .FIFO_DEPTH (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .din_vld  (din_vld),
    .din_rdy  (din_rdy),
    .txd      (txd),
    .busy     (busy),
    .fifo_cnt (fifo_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n;
    n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, int'(busy), 0);
  endtask

  // Bench UART decoder: it samples near the centre of each bit, with 4 cycles per bit.
  initial begin : decoder
    int         s;
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (dec_en && txd == 1'b0) begin
        s = cyc;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (4) @(negedge clk);
          b[i] = txd;
        end
        repeat (4) @(negedge clk);
        check("stop_bit", int'(txd), 1);
        rx_q.push_back(b);
        st_q.push_back(s);
      end
    end
  end

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;  // frame[i] is the i-th bit on the line: start, d0..d7, stop
  } vec_t;

  vec_t vecs[5];

  initial begin : main
    logic [7:0] bb[3];
    int         exp_cnt[3];
    int         nxt;
    int         n;
    int         bad;
    int         mism;
    bit         saw_full;
    bit         ok;

    vecs[0] = '{data: 8'h52, frame: 10'b1_0101_0010_0};
    vecs[1] = '{data: 8'hA5, frame: 10'b1_1010_0101_0};
    vecs[2] = '{data: 8'h00, frame: 10'b1_0000_0000_0};
    vecs[3] = '{data: 8'hFF, frame: 10'b1_1111_1111_0};
    vecs[4] = '{data: 8'h0D, frame: 10'b1_0000_1101_0};

    rst     = 1'b0;
    din     = 8'h00;
    din_vld = 1'b0;

    // Reset values: the reset is asserted between edges and checked before any clock.
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_txd", int'(txd), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_fifo_cnt", int'(fifo_cnt), 0);
    check("rst_din_rdy", int'(din_rdy), 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("idle_txd", int'(txd), 1);
    end
    check("idle_busy", int'(busy), 0);
    rx_q.delete();
    st_q.delete();
    dec_en = 1;

    // Single-byte frames from a table, checked on every cycle of the frame.
    foreach (vecs[v]) begin
      @(negedge clk);
      din     = vecs[v].data;
      din_vld = 1'b1;
      @(posedge clk);            // edge k: the byte is pushed
      @(negedge clk);
      din_vld = 1'b0;
      check($sformatf("v%0d_cnt_k", v), int'(fifo_cnt), 1);
      check($sformatf("v%0d_txd_k", v), int'(txd), 1);
      @(negedge clk);            // after edge k+1: the byte is popped, txd still high
      check($sformatf("v%0d_cnt_k1", v), int'(fifo_cnt), 0);
      check($sformatf("v%0d_txd_k1", v), int'(txd), 1);
      check($sformatf("v%0d_busy_k1", v), int'(busy), 1);
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);          // after edge k+2+c
        check($sformatf("v%0d_txd_c%0d", v, c), int'(txd), int'(vecs[v].frame[c / 4]));
      end
      check($sformatf("v%0d_busy_end", v), int'(busy), 0);
      check($sformatf("v%0d_rx_n", v), rx_q.size(), 1);
      check($sformatf("v%0d_rx", v), int'(rx_q[0]), int'(vecs[v].data));
      rx_q.delete();
      st_q.delete();
    end

    // Back-to-back: three pushes in consecutive cycles.
    bb[0] = 8'h44; bb[1] = 8'h20; bb[2] = 8'h0D;
    exp_cnt[0] = 1; exp_cnt[1] = 1; exp_cnt[2] = 2;
    @(negedge clk);
    din     = bb[0];
    din_vld = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("b2b_cnt%0d", i), int'(fifo_cnt), exp_cnt[i]);
      if (i < 2) din = bb[i + 1];
      else din_vld = 1'b0;
    end
    wait_idle(300, "b2b_timeout");
    check("b2b_drained", int'(fifo_cnt), 0);
    check("b2b_rx_n", rx_q.size(), 3);
    for (int i = 0; i < 3; i++) check($sformatf("b2b_rx%0d", i), int'(rx_q[i]), int'(bb[i]));
    check("b2b_gap01", st_q[1] - st_q[0], 40);
    check("b2b_gap12", st_q[2] - st_q[1], 40);
    rx_q.delete();
    st_q.delete();

    // Full FIFO: the producer holds din_vld high with incrementing data.
    nxt = 0; n = 0; bad = 0; saw_full = 0;
    while (nxt < 10 && n < 2000) begin
      @(negedge clk);
      din     = 8'(nxt);
      din_vld = 1'b1;
      if (fifo_cnt == 3'd4) saw_full = 1;
      if (din_rdy != (fifo_cnt != 3'd4)) bad++;
      ok = din_rdy;
      @(posedge clk);
      if (ok) nxt++;
      n++;
    end
    @(negedge clk);
    din_vld = 1'b0;
    check("full_all_pushed", nxt, 10);
    check("full_seen", int'(saw_full), 1);
    check("full_rdy_bad", bad, 0);
    wait_idle(1000, "full_timeout");
    check("full_rx_n", rx_q.size(), 10);
    mism = 0;
    for (int i = 0; i < 10; i++) if (rx_q[i] != 8'(i)) mism++;
    check("full_rx_seq", mism, 0);
    rx_q.delete();
    st_q.delete();

    // Reset during data bit 3 of 0x11 with two bytes queued.
    bb[0] = 8'h11; bb[1] = 8'h22; bb[2] = 8'h33;
    @(negedge clk);
    din     = bb[0];
    din_vld = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i < 2) din = bb[i + 1];
      else din_vld = 1'b0;
    end
    check("mid_cnt_q", int'(fifo_cnt), 2);
    repeat (17) @(posedge clk);  // edge k+19, inside data bit 3
    #2;
    check("mid_txd_pre", int'(txd), 0);
    rst = 1'b1;
    #1;
    check("mid_txd_rst", int'(txd), 1);
    check("mid_cnt_rst", int'(fifo_cnt), 0);
    check("mid_busy_rst", int'(busy), 0);
    check("mid_rdy_rst", int'(din_rdy), 1);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("mid_idle_txd", int'(txd), 1);
    check("mid_idle_busy", int'(busy), 0);
    rx_q.delete();
    st_q.delete();
    @(negedge clk);
    din     = 8'hA5;
    din_vld = 1'b1;
    @(negedge clk);
    din_vld = 1'b0;
    wait_idle(200, "mid_timeout");
    @(negedge clk);
    check("mid_rx_n", rx_q.size(), 1);
    check("mid_rx", int'(rx_q[0]), 8'hA5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
